score_scan_mux: RTL and testbench

- Upstream feeder for the 4-bit-in / 7-bit-out seven-segment decoder in the dino game display path.
- Keeps the running game score as packed BCD and latches the best score at game over.
- Time-multiplexes the selected score over NUM_DIGITS common-anode digits: one BCD nibble plus a one-hot active-low anode select per scan slot.
- The decoder converts digit_bcd into segments; an_n drives the digit enables directly.

---
 rtl/dino_disp_pkg.sv | 17 +
 rtl/bcd_digit_cell.sv | 26 ++
 rtl/score_scan_mux.sv | 127 ++++++++++++
 tb/tb_score_scan_mux.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dino_disp_pkg.sv
// Shared types and helpers for the dino game display path (BCD score digits).
package dino_disp_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int MAX_DIGITS = 8;
  localparam int BCD_VEC_W = MAX_DIGITS * BCD_W;

  typedef logic [BCD_W-1:0] bcd_t;

  // Packed BCD orders the same as unsigned binary, so a plain compare suffices.
  function automatic logic bcd_gt(input logic [BCD_VEC_W-1:0] a,
                                  input logic [BCD_VEC_W-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the score counter: 0..9 with combinational carry to the next decade.
module bcd_digit_cell
  import dino_disp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc_in,
  input  logic hold,
  output bcd_t q,
  output logic carry_out
);

  assign carry_out = inc_in && (q == BCD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc_in && !hold) begin
      q <= (q == BCD_MAX) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/score_scan_mux.sv
// Game score / best score keeper and multiplexed digit scanner for a 7-seg decoder.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module score_scan_mux
  import dino_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  score_inc,
  input  logic                  score_clr,
  input  logic                  freeze,
  input  logic                  show_best,
  output logic [3:0]            digit_bcd,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  sat
);

  localparam int W  = NUM_DIGITS * BCD_W;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [W-1:0]          score;
  logic [W-1:0]          best;
  logic [W-1:0]          disp;
  logic [NUM_DIGITS-1:0] carry;
  logic [NUM_DIGITS-1:0] nine;
  logic                  all_nines;
  logic                  inc_en;
  logic                  freeze_d;
  logic [PW-1:0]         pre;
  logic [IW-1:0]         idx;
  logic [BCD_VEC_W-1:0]  score_ext;
  logic [BCD_VEC_W-1:0]  best_ext;
  logic [NUM_DIGITS-1:0] an_next;
  bcd_t                  nib_next;

  assign inc_en    = score_inc && !freeze && !score_clr;
  assign all_nines = &nine;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
    logic inc_in;
    bcd_t q;
    if (gi == 0) begin : g_lsd
      assign inc_in = inc_en;
    end else begin : g_upper
      assign inc_in = carry[gi-1];
    end
    bcd_digit_cell u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (score_clr),
      .inc_in    (inc_in),
      .hold      (all_nines),
      .q         (q),
      .carry_out (carry[gi])
    );
    assign score[gi*BCD_W +: BCD_W] = q;
    assign nine[gi] = (q == BCD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat <= 1'b0;
    end else if (score_clr) begin
      sat <= 1'b0;
    end else if (inc_en && all_nines) begin
      sat <= 1'b1;
    end
  end

  always_comb begin
    score_ext = '0;
    best_ext  = '0;
    score_ext[W-1:0] = score;
    best_ext[W-1:0]  = best;
  end

  // score here is the pre-clear value, so a clear on the game-over edge still records it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freeze_d <= 1'b0;
      best     <= '0;
    end else begin
      freeze_d <= freeze;
      if (freeze && !freeze_d && bcd_gt(score_ext, best_ext)) begin
        best <= score;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PW'(SCAN_DIV - 1)) begin
      pre <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign disp = show_best ? best : score;

  always_comb begin
    nib_next = disp[idx*BCD_W +: BCD_W];
    an_next  = ~(NUM_DIGITS'(1) << idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx != '0 && (disp >> (idx * BCD_W)) == '0) begin
      an_next = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_bcd <= '0;
      an_n      <= '1;
    end else begin
      digit_bcd <= nib_next;
      an_n      <= an_next;
    end
  end

endmodule

// File: tb/tb_score_scan_mux.sv
// Directed bench for score_scan_mux with NUM_DIGITS=4, SCAN_DIV=4.
module tb_score_scan_mux;

  logic       clk;
  logic       rst_n;
  logic       score_inc;
  logic       score_clr;
  logic       freeze;
  logic       show_best;
  logic [3:0] digit_bcd;
  logic [3:0] an_n;
  logic       sat;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  score_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .score_inc (score_inc),
    .score_clr (score_clr),
    .freeze    (freeze),
    .show_best (show_best),
    .digit_bcd (digit_bcd),
    .an_n      (an_n),
    .sat       (sat)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // posedges since reset release; scan slot lit after edge n is ((n-1)/4)%4
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int exp_slot();
    return ((cyc - 1) / 4) % 4;
  endfunction

  task automatic chk4(input logic [3:0] obs, input logic [3:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_slot(input int s, input logic [15:0] v, input string tag);
    int k;
    logic [3:0] ed;
    logic [3:0] ea;
    logic [3:0] one;
    k = 0;
    @(negedge clk);
    while (exp_slot() != s && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: slot %0d never reached", tag, s);
    end else begin
      ed  = v[4*s +: 4];
      one = 4'b0001;
      ea  = ~(one << s);
`ifdef LEADING_ZERO_BLANK_EN
      if (s > 0 && (v >> (4 * s)) == 16'h0) ea = 4'hF;
`endif
      chk4(digit_bcd, ed, $sformatf("%s_dig%0d", tag, s));
      chk4(an_n, ea, $sformatf("%s_an%0d", tag, s));
    end
  endtask

  task automatic check_value(input logic [15:0] v, input string tag);
    for (int s = 0; s < 4; s++) check_slot(s, v, tag);
  endtask

  // driver tasks: called and returning on a negedge
  task automatic inc_n(input int n);
    score_inc = 1'b1;
    repeat (n) @(negedge clk);
    score_inc = 1'b0;
  endtask

  task automatic clr_pulse();
    score_clr = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
  endtask

  initial begin
    int s;
    logic [15:0] best_v;
    rst_n     = 1'b0;
    score_inc = 1'b0;
    score_clr = 1'b0;
    freeze    = 1'b0;
    show_best = 1'b0;
    repeat (3) @(negedge clk);
    chk4(an_n, 4'hF, "rst_an");
    chk4(digit_bcd, 4'h0, "rst_dig");
    chk1(sat, 1'b0, "rst_sat");
    rst_n = 1'b1;

    // scan timing
    wait_cyc(1);  chk4(an_n, 4'b1110, "scan_c1");
    chk4(digit_bcd, 4'h0, "scan_dig");
    wait_cyc(5);  chk4(an_n, 4'b1101, "scan_c5");
    wait_cyc(9);  chk4(an_n, 4'b1011, "scan_c9");
    wait_cyc(13); chk4(an_n, 4'b0111, "scan_c13");
    wait_cyc(17); chk4(an_n, 4'b1110, "scan_c17");

    // counting
    inc_n(123);
    check_value(16'h0123, "s123");
    chk1(sat, 1'b0, "s123_sat");
    clr_pulse();
    inc_n(999);
    check_value(16'h0999, "s999");
    inc_n(1);
    check_value(16'h1000, "s1000");

    // saturation
    clr_pulse();
    inc_n(9999);
    check_value(16'h9999, "s9999");
    chk1(sat, 1'b0, "s9999_sat0");
    inc_n(1);
    check_value(16'h9999, "sat_hold");
    chk1(sat, 1'b1, "sat_set");
    clr_pulse();
    check_value(16'h0000, "sat_clr");
    chk1(sat, 1'b0, "sat_cleared");

    // best capture with clear on the game-over edge
    inc_n(457);
    freeze    = 1'b1;
    score_clr = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
    check_value(16'h0000, "go_score");
    show_best = 1'b1;
    check_value(16'h0457, "go_best");
    show_best = 1'b0;
    freeze    = 1'b0;
    @(negedge clk);
    inc_n(300);
    check_value(16'h0300, "s300");
    freeze = 1'b1;
    @(negedge clk);

    // show_best toggle affects the lit digit on the next cycle
    best_v = 16'h0457;
    show_best = 1'b1;
    @(negedge clk);
    s = exp_slot();
    chk4(digit_bcd, best_v[4*s +: 4], "toggle_dig");
    check_value(16'h0457, "best_kept");
    show_best = 1'b0;

    // frozen increments ignored, clear beats increment
    inc_n(5);
    check_value(16'h0300, "frozen");
    freeze = 1'b0;
    @(negedge clk);
    score_inc = 1'b1;
    score_clr = 1'b1;
    @(negedge clk);
    score_inc = 1'b0;
    score_clr = 1'b0;
    check_value(16'h0000, "inc_clr");

    // leading-zero pattern (blanked only when the macro is defined)
    inc_n(42);
    check_value(16'h0042, "s42");
    clr_pulse();
    check_value(16'h0000, "s0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
